tdm_demux_1_8: RTL and testbench
================================

Name: tdm_demux_1_8

Overview:
Sequential 1:8 time-division demultiplexer. It is the receive end of the 8:1 channel mux path. A serial stream of WIDTH-bit samples arrives one slot per EN strobe, with SYNC marking slot 0. The block routes each slot into channel registers A..H and publishes a complete, coherent frame once all 8 slots have been captured.

Parameters:
WIDTH, 1, bits per channel sample; applies to D_IN and to each of the outputs A..H.

Ports:
CLK  input  1  single clock; all logic on the rising edge.
RST_N  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
EN  input  1  slot strobe; D_IN and SYNC are valid only when EN=1.
SYNC  input  1  frame marker; qualified by EN; marks slot 0.
D_IN  input  WIDTH  serial TDM sample.
A..H  output  WIDTH each  registered channel outputs for slots 0..7, eight separate ports.
SEL  output  3  slot index the next EN sample will be written to (S2..S0 order, MSB first).
FRAME_VALID  output  1  one-cycle pulse when A..H update.
SYNC_ERR  output  1  one-cycle pulse on a misplaced SYNC.
PAR_ERR  output  1  one-cycle pulse on a parity mismatch; tied 0 when TDM_DEMUX_PARITY_EN is undefined.

Behaviour:
- Reset (RST_N=0 at a CLK edge): A..H=0, SEL=0, FRAME_VALID=0, SYNC_ERR=0, PAR_ERR=0, shadow registers=0, state=HUNT. Reset mid-frame discards the partial frame; A..H keep no prior value and read 0.
- State HUNT:
  - EN=1 with SYNC=0: sample ignored; SEL stays 0.
  - EN=1 with SYNC=1: capture D_IN into shadow[0], SEL->1, go to LOCKED.
- State LOCKED, EN=1, SYNC=0: capture D_IN into shadow[SEL], then SEL increments.
- State LOCKED, EN=1, SYNC=1, SEL=0: normal frame start; capture into shadow[0], SEL->1.
- State LOCKED, EN=1, SYNC=1, SEL!=0: misaligned.
  - SYNC_ERR pulses next cycle.
  - Partial frame is discarded; A..H are not updated.
  - The sample is captured as shadow[0], SEL->1; the block stays LOCKED (resync).
- Last slot (SEL=7 without parity; SEL=8 internal with parity) accepted with SYNC=0:
  - Next cycle: A..H <= shadow[0..7] (with D_IN forwarded for slot 7, so there are no bubbles) and FRAME_VALID=1 for exactly one cycle.
  - SEL wraps to 0.
- Latency: A..H update 1 cycle after the EN cycle that carries the final slot.
- Outputs A..H hold between frames; they never show a mix of two frames.
- EN=0: no state change. Any number of idle cycles may separate slots.
- Back-to-back frames with EN=1 every cycle: FRAME_VALID pulses every 8 cycles (9 with parity).
- A SYNC on the final slot is treated as misaligned (SEL!=0).
- SEL is registered and reflects the post-update index. In HUNT, SEL=0.

Optional Feature:
Macro TDM_DEMUX_PARITY_EN.
- Defined:
  - Frame is 9 slots; slot 8 carries the even-parity word, bitwise XOR of the 8 channel samples.
  - SEL stays 3 bits; an internal 4-bit counter tracks slot 8, and SEL reads 0 during slot 8.
  - On slot 8: if D_IN equals the XOR of shadow[0..7], publish as above.
  - On mismatch: PAR_ERR pulses for 1 cycle, A..H are unchanged, FRAME_VALID stays 0, and the counter wraps to 0 (state LOCKED).
- Undefined: 8-slot frame, no parity logic, PAR_ERR constant 0.

Test Plan:
1. Reset, WIDTH=1, EN=1 every cycle, SYNC on slot 0, D_IN=1,0,1,1,0,0,1,0 -> one cycle after the 8th sample, A..H=1,0,1,1,0,0,1,0 and FRAME_VALID=1 for one cycle; SEL sequence is 0,1,...,7,0.
2. In HUNT, drive 5 EN samples with SYNC=0, then a valid frame -> the first 5 samples are ignored; only the valid frame appears on A..H.
3. WIDTH=4, frame with idle EN=0 gaps of 0-3 cycles between slots, values 0x1..0x8 -> A..H=0x1..0x8; FRAME_VALID pulses once; outputs are stable during the gaps.
4. Mid-frame SYNC at SEL=4 -> SYNC_ERR pulses for 1 cycle; A..H keep the previous frame; the new frame starts from that sample and completes correctly 7 samples later.
5. Assert RST_N=0 for 1 cycle at SEL=5 -> all outputs 0, state HUNT; the next frame without SYNC is ignored.
6. With TDM_DEMUX_PARITY_EN, send channels 0x3,0x5,0,0,0,0,0,0:
   - Parity 0x6 -> A..H updated, FRAME_VALID=1.
   - Parity 0x7 -> PAR_ERR=1, A..H unchanged, FRAME_VALID=0.

Source files
------------

// File: rtl/tdm_demux_1_8_if.sv
// Signal bundle for the 1:8 TDM demultiplexer: serial sample input side and channel output side.
interface tdm_demux_1_8_if #(
  parameter int unsigned Width = 1
);
  logic             en;
  logic             sync;
  logic [Width-1:0] d_in;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic [Width-1:0] c;
  logic [Width-1:0] d;
  logic [Width-1:0] e;
  logic [Width-1:0] f;
  logic [Width-1:0] g;
  logic [Width-1:0] h;
  logic [2:0]       sel;
  logic             frame_valid;
  logic             sync_err;
  logic             par_err;

  modport master (
    output en, sync, d_in,
    input  a, b, c, d, e, f, g, h, sel, frame_valid, sync_err, par_err
  );

  modport slave (
    input  en, sync, d_in,
    output a, b, c, d, e, f, g, h, sel, frame_valid, sync_err, par_err
  );
endinterface

// File: rtl/tdm_demux_1_8.sv
// 1:8 TDM demultiplexer: captures one slot per strobe into shadow registers, publishes whole frames.
// Optional even-parity slot 8 is enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux_1_8 #(
  parameter int unsigned Width = 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  tdm_demux_1_8_if.slave bus
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int unsigned CntW = 4;
`else
  localparam int unsigned CntW = 3;
`endif
  localparam logic [CntW-1:0] LastSlot = CntW'(`ifdef TDM_DEMUX_PARITY_EN 8 `else 7 `endif);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [Width-1:0] shadow_q [8];
  logic [Width-1:0] out_q    [8];
  logic             fv_q;
  logic             se_q;

`ifdef TDM_DEMUX_PARITY_EN
  logic             pe_q;
  logic [Width-1:0] par_calc;

  always_comb begin
    par_calc = '0;
    for (int i = 0; i < 8; i++) begin
      par_calc = par_calc ^ shadow_q[i];
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StHunt;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      pe_q    <= 1'b0;
`endif
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= '0;
        out_q[i]    <= '0;
      end
    end else begin
      fv_q <= 1'b0;
      se_q <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      pe_q <= 1'b0;
`endif
      if (bus.en) begin
        unique case (state_q)
          StHunt: begin
            if (bus.sync) begin
              shadow_q[0] <= bus.d_in;
              cnt_q       <= CntW'(1);
              state_q     <= StLocked;
            end
          end
          StLocked: begin
            if (bus.sync) begin
              // Any SYNC away from slot 0 (including on the last slot) restarts the frame here.
              se_q        <= (cnt_q != '0);
              shadow_q[0] <= bus.d_in;
              cnt_q       <= CntW'(1);
            end else if (cnt_q == LastSlot) begin
              cnt_q <= '0;
`ifdef TDM_DEMUX_PARITY_EN
              if (bus.d_in == par_calc) begin
                for (int i = 0; i < 8; i++) begin
                  out_q[i] <= shadow_q[i];
                end
                fv_q <= 1'b1;
              end else begin
                pe_q <= 1'b1;
              end
`else
              // Slot 7 goes straight from the input so the frame publishes without a bubble.
              for (int i = 0; i < 7; i++) begin
                out_q[i] <= shadow_q[i];
              end
              out_q[7] <= bus.d_in;
              fv_q     <= 1'b1;
`endif
            end else begin
              shadow_q[cnt_q[2:0]] <= bus.d_in;
              cnt_q                <= cnt_q + CntW'(1);
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

  assign bus.a           = out_q[0];
  assign bus.b           = out_q[1];
  assign bus.c           = out_q[2];
  assign bus.d           = out_q[3];
  assign bus.e           = out_q[4];
  assign bus.f           = out_q[5];
  assign bus.g           = out_q[6];
  assign bus.h           = out_q[7];
  // During parity slot 8 the low three bits read 0, as required for SEL.
  assign bus.sel         = cnt_q[2:0];
  assign bus.frame_valid = fv_q;
  assign bus.sync_err    = se_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.par_err     = pe_q;
`else
  assign bus.par_err     = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_1_8.sv
// Bench for tdm_demux_1_8: directed frames plus random strobes checked against a frame-queue model.
module tb_tdm_demux_1_8;
  localparam int unsigned W = 4;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FrameLen = 9;
`else
  localparam int FrameLen = 8;
`endif

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  tdm_demux_1_8_if #(.Width(W)) bus ();

  tdm_demux_1_8 #(.Width(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: locked flag, samples accepted in the current frame, published channels.
  bit           m_locked;
  logic [W-1:0] m_frm [$];
  logic [W-1:0] m_out [8];
  bit           m_fv, m_se, m_pe;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit sync, input logic [W-1:0] d);
    logic [8*W-1:0] exp_ch;
    logic [8*W-1:0] got_ch;
    logic [W-1:0]   x;
    @(negedge clk);
    rst_n    = !rst;
    bus.en   = en;
    bus.sync = sync;
    bus.d_in = d;
    @(posedge clk);
    m_fv = 0;
    m_se = 0;
    m_pe = 0;
    if (rst) begin
      m_locked = 0;
      m_frm.delete();
      for (int i = 0; i < 8; i++) m_out[i] = '0;
    end else if (en) begin
      if (!m_locked) begin
        if (sync) begin
          m_locked = 1;
          m_frm.delete();
          m_frm.push_back(d);
        end
      end else if (sync) begin
        if (m_frm.size() != 0) m_se = 1;
        m_frm.delete();
        m_frm.push_back(d);
      end else begin
        m_frm.push_back(d);
        if (m_frm.size() == FrameLen) begin
          x = '0;
          for (int i = 0; i < 8; i++) x ^= m_frm[i];
`ifdef TDM_DEMUX_PARITY_EN
          if (m_frm[8] != x) m_pe = 1;
`endif
          if (!m_pe) begin
            for (int i = 0; i < 8; i++) m_out[i] = m_frm[i];
            m_fv = 1;
          end
          m_frm.delete();
        end
      end
    end
    #1;
    for (int i = 0; i < 8; i++) exp_ch[i*W +: W] = m_out[i];
    got_ch = {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
    chk("channels", 64'(got_ch), 64'(exp_ch));
    chk("sel", 64'(bus.sel), m_locked ? 64'(m_frm.size() % 8) : 64'd0);
    chk("frame_valid", 64'(bus.frame_valid), 64'(m_fv));
    chk("sync_err", 64'(bus.sync_err), 64'(m_se));
    chk("par_err", 64'(bus.par_err), 64'(m_pe));
  endtask

  // Sends one frame with SYNC on slot 0, random idle gaps, and (if enabled) a parity word.
  task automatic send_frame(input logic [8*W-1:0] v, input int max_gap, input bit bad_par);
    logic [W-1:0] x;
    x = '0;
    for (int i = 0; i < FrameLen; i++) begin
      logic [W-1:0] s;
      if (i < 8) begin
        s = v[i*W +: W];
        x ^= s;
      end else begin
        s = bad_par ? (x ^ W'(1)) : x;
      end
      step(0, 1, i == 0, s);
      repeat ($urandom_range(max_gap, 0)) step(0, 0, 0, W'($urandom));
    end
  endtask

  initial begin
    int           gslot;
    logic [W-1:0] gx;
    logic [W-1:0] d;
    bit           sy;
    int           r;
    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.sync = 1'b0;
    bus.d_in = '0;
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);

    // 1: basic frame, EN every cycle.
    send_frame({4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1}, 0, 0);
    step(0, 0, 0, '0);
    // 2: samples without SYNC in HUNT are ignored.
    step(1, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, W'(i + 9));
    send_frame({4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE, 4'hF}, 0, 0);
    // 3: idle gaps between slots.
    send_frame({4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1}, 3, 0);
    step(0, 0, 0, '0);
    // 4: SYNC at SEL=4 restarts the frame.
    for (int i = 0; i < 4; i++) step(0, 1, i == 0, W'(i + 3));
    send_frame({4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2}, 1, 0);
    // 5: reset at SEL=5, then a frame without SYNC is ignored.
    for (int i = 0; i < 5; i++) step(0, 1, i == 0, W'(i + 1));
    step(1, 0, 0, '0);
    for (int i = 0; i < FrameLen; i++) step(0, 1, 0, W'(i + 5));
`ifdef TDM_DEMUX_PARITY_EN
    // 6: good parity publishes, bad parity flags and holds outputs.
    send_frame({4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h3}, 0, 0);
    send_frame({4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h3}, 0, 1);
    step(0, 0, 0, '0);
`endif

    // Random strobes: mostly well-formed frames with occasional misplaced SYNC, bad parity, reset.
    gslot = 0;
    gx    = '0;
    repeat (800) begin
      r = int'($urandom % 100);
      if (r < 1) begin
        step(1, 0, 0, '0);
        gslot = 0;
      end else if (r < 30) begin
        step(0, 0, int'($urandom % 2) == 1, W'($urandom));
      end else begin
        sy = (gslot == 0) ? ($urandom % 10 != 0) : ($urandom % 25 == 0);
        if (sy) begin
          gslot = 0;
          gx    = '0;
        end
        d = W'($urandom);
        if (gslot == 8) d = ($urandom % 5 == 0) ? (gx ^ W'(2)) : gx;
        else gx ^= d;
        step(0, 1, sy, d);
        gslot = (gslot + 1) % FrameLen;
        if (gslot == 0) gx = '0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
